// File: rtl/ascon_reg_bank.sv
// Ascon operand register bank: three REG_W-bit registers with serial load,
// core writeback and an MSB-first serial readout transmitter.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   shift_in_en/_sel/_bit       serial load, one bit per cycle into the LSB
//   reg_128b_wrback_en/_sel/_val  parallel writeback from the core
//   rd_start, rd_sel            request a serial readout of reg0..reg2
//   reg0_128b..reg2_128b        register contents (direct flop outputs)
//   rd_busy, rd_valid, rd_bit, rd_done  registered readout stream
module ascon_reg_bank #(
    parameter int REG_W = 128,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_in_en,
    input  logic [1:0]       shift_in_sel,
    input  logic             shift_in_bit,
    input  logic             reg_128b_wrback_en,
    input  logic [1:0]       reg_128b_wrback_sel,
    input  logic [REG_W-1:0] reg_128b_wrback_val,
    input  logic             rd_start,
    input  logic [1:0]       rd_sel,
    output logic [REG_W-1:0] reg0_128b,
    output logic [REG_W-1:0] reg1_128b,
    output logic [REG_W-1:0] reg2_128b,
    output logic             rd_busy,
    output logic             rd_valid,
    output logic             rd_bit,
    output logic             rd_done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [REG_W-1:0] reg_q [3];

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [REG_W-1:0] snap_q;
    logic [REG_W-1:0] snap_d;
    logic             busy_d;
    logic             valid_d;
    logic             bit_d;
    logic             done_d;
    logic [REG_W-1:0] rd_src;

    assign reg0_128b = reg_q[0];
    assign reg1_128b = reg_q[1];
    assign reg2_128b = reg_q[2];

    // Writeback has priority over a shift into the same register; loads
    // aimed at different registers proceed independently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (reg_128b_wrback_en && reg_128b_wrback_sel == 2'(i)) begin
                    reg_q[i] <= reg_128b_wrback_val;
                end else if (shift_in_en && shift_in_sel == 2'(i)) begin
                    reg_q[i] <= {reg_q[i][REG_W-2:0], shift_in_bit};
                end
            end
        end
    end

    always_comb begin
        rd_src = '0;
        unique case (1'b1)
            rd_sel == 2'd0: rd_src = reg_q[0];
            rd_sel == 2'd1: rd_src = reg_q[1];
            rd_sel == 2'd2: rd_src = reg_q[2];
            default:        rd_src = '0;
        endcase
    end

    // Outputs are registered, so the next-cycle values are computed here
    // from the counter value that the next cycle will present.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        bit_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_start && rd_sel != 2'd3) begin
                    state_d = SHIFT;
                    snap_d  = rd_src;
                    cnt_d   = CNT_W'(REG_W - 1);
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    bit_d   = rd_src[REG_W-1];
                    done_d  = (cnt_d == '0);
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    bit_d   = snap_q[cnt_d];
                    done_d  = (cnt_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            snap_q   <= '0;
            rd_busy  <= 1'b0;
            rd_valid <= 1'b0;
            rd_bit   <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            rd_busy  <= busy_d;
            rd_valid <= valid_d;
            rd_bit   <= bit_d;
            rd_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_ascon_reg_bank.sv
// Scoreboard bench for ascon_reg_bank: directed scenarios plus random
// traffic against a register/stream model kept in the bench.
module tb_ascon_reg_bank;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         shift_in_en;
    logic [1:0]   shift_in_sel;
    logic         shift_in_bit;
    logic         wb_en;
    logic [1:0]   wb_sel;
    logic [127:0] wb_val;
    logic         rd_start;
    logic [1:0]   rd_sel;
    logic [127:0] reg0_128b;
    logic [127:0] reg1_128b;
    logic [127:0] reg2_128b;
    logic         rd_busy;
    logic         rd_valid;
    logic         rd_bit;
    logic         rd_done;

    always #5 clk = ~clk;

    ascon_reg_bank dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .shift_in_en         (shift_in_en),
        .shift_in_sel        (shift_in_sel),
        .shift_in_bit        (shift_in_bit),
        .reg_128b_wrback_en  (wb_en),
        .reg_128b_wrback_sel (wb_sel),
        .reg_128b_wrback_val (wb_val),
        .rd_start            (rd_start),
        .rd_sel              (rd_sel),
        .reg0_128b           (reg0_128b),
        .reg1_128b           (reg1_128b),
        .reg2_128b           (reg2_128b),
        .rd_busy             (rd_busy),
        .rd_valid            (rd_valid),
        .rd_bit              (rd_bit),
        .rd_done             (rd_done)
    );

    int errors = 0;
    int checks = 0;

    // Model: register contents, stream bits still owed, expected {bit,done}.
    logic [127:0] m_reg [3] = '{default: '0};
    int           rem = 0;
    logic [1:0]   exp_q [$];
    bit           mon_en = 0;
    int           seen_valid = 0;
    int           seen_ones = 0;
    int           seen_done = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        shift_in_en  = 1'b0;
        shift_in_sel = 2'd3;
        shift_in_bit = 1'b0;
        wb_en        = 1'b0;
        wb_sel       = 2'd3;
        wb_val       = '0;
        rd_start     = 1'b0;
        rd_sel       = 2'd3;
    endtask

    // One clock: apply the model to the inputs held across the edge.
    task automatic tick();
        int s;
        int w;
        @(posedge clk);
        if (!rst_n) begin
            m_reg = '{default: '0};
            rem   = 0;
            exp_q.delete();
        end else begin
            if (rem > 0) begin
                rem--;
            end else if (rd_start && rd_sel != 2'd3) begin
                rem = 128;
                for (int i = 127; i >= 0; i--) begin
                    exp_q.push_back({m_reg[rd_sel][i], i == 0});
                end
            end
            s = int'(shift_in_sel);
            w = int'(wb_sel);
            if (shift_in_en && s != 3 && !(wb_en && w == s)) begin
                m_reg[s] = {m_reg[s][126:0], shift_in_bit};
            end
            if (wb_en && w != 3) begin
                m_reg[w] = wb_val;
            end
        end
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            chk("rd_busy", 128'(rd_busy), 128'(rem > 0));
            chk("rd_valid", 128'(rd_valid), 128'(rem > 0));
            if (rd_valid === 1'b1) begin
                seen_valid++;
                if (rd_bit === 1'b1) seen_ones++;
                if (rd_done === 1'b1) seen_done++;
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected", 128'(rd_valid), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_bit", 128'(rd_bit), 128'(e[1]));
                    chk("rd_done", 128'(rd_done), 128'(e[0]));
                end
            end else begin
                chk("idle_bit_done", 128'({rd_bit, rd_done}), 128'(0));
            end
            chk("reg0", reg0_128b, m_reg[0]);
            chk("reg1", reg1_128b, m_reg[1]);
            chk("reg2", reg2_128b, m_reg[2]);
        end
    end

    initial begin
        logic [127:0] pat;
        logic [127:0] sv0;
        logic [127:0] sv1;
        logic [127:0] sv2;

        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        mon_en = 1;
        chk("reset_regs", reg0_128b | reg1_128b | reg2_128b, '0);
        chk("reset_outs", 128'({rd_busy, rd_valid, rd_bit, rd_done}), '0);
        rst_n = 1'b1;

        // Serial load of reg1, first bit lands at the MSB.
        pat = 128'h0123456789ABCDEF_FEDCBA9876543210;
        for (int i = 127; i >= 0; i--) begin
            shift_in_en  = 1'b1;
            shift_in_sel = 2'd1;
            shift_in_bit = pat[i];
            tick();
        end
        idle_in();
        chk("load_reg1", reg1_128b, pat);
        chk("load_reg0", reg0_128b, '0);
        chk("load_reg2", reg2_128b, '0);

        // Writeback to reg2, then an ignored sel=3 writeback.
        wb_en  = 1'b1;
        wb_sel = 2'd2;
        wb_val = {16{8'hA5}};
        tick();
        chk("wb_reg2", reg2_128b, {16{8'hA5}});
        sv0 = reg0_128b;
        sv1 = reg1_128b;
        sv2 = reg2_128b;
        wb_sel = 2'd3;
        wb_val = {4{$urandom}};
        tick();
        chk("wb_sel3_r0", reg0_128b, sv0);
        chk("wb_sel3_r1", reg1_128b, sv1);
        chk("wb_sel3_r2", reg2_128b, sv2);

        // Collisions: writeback wins on the same register.
        wb_sel = 2'd0;
        wb_val = {4{$urandom}} | 128'h1;
        tick();
        shift_in_en  = 1'b1;
        shift_in_sel = 2'd0;
        shift_in_bit = 1'b1;
        wb_val       = '0;
        tick();
        chk("collide_same", reg0_128b, '0);
        shift_in_sel = 2'd1;
        wb_val       = {4{$urandom}};
        sv0          = wb_val;
        tick();
        chk("collide_diff_r0", reg0_128b, sv0);
        chk("collide_diff_r1", reg1_128b, {pat[126:0], 1'b1});
        idle_in();

        // Readout of 0x8000..0001 from reg0.
        wb_en  = 1'b1;
        wb_sel = 2'd0;
        wb_val = {1'b1, 126'b0, 1'b1};
        tick();
        idle_in();
        seen_valid = 0;
        seen_ones  = 0;
        seen_done  = 0;
        rd_start = 1'b1;
        rd_sel   = 2'd0;
        tick();
        idle_in();
        repeat (130) tick();
        chk("rd_valid_cycles", 128'(seen_valid), 128'(128));
        chk("rd_ones", 128'(seen_ones), 128'(2));
        chk("rd_done_count", 128'(seen_done), 128'(1));

        // Readout of reg1 with a writeback and a second request at N+5.
        sv1 = reg1_128b;
        seen_valid = 0;
        seen_ones  = 0;
        rd_start = 1'b1;
        rd_sel   = 2'd1;
        tick();
        idle_in();
        repeat (4) tick();
        rd_start = 1'b1;
        rd_sel   = 2'd2;
        wb_en    = 1'b1;
        wb_sel   = 2'd1;
        wb_val   = '1;
        tick();
        idle_in();
        repeat (130) tick();
        chk("rd_snapshot_valid", 128'(seen_valid), 128'(128));
        chk("rd_snapshot_ones", 128'(seen_ones), 128'($countones(sv1)));
        chk("wb_during_rd", reg1_128b, '1);

        // Reset at N+40 of a readout.
        seen_done = 0;
        rd_start = 1'b1;
        rd_sel   = 2'd2;
        tick();
        idle_in();
        repeat (39) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_outs", 128'({rd_busy, rd_valid, rd_done}), '0);
        chk("rst_mid_regs", reg0_128b | reg1_128b | reg2_128b, '0);
        repeat (100) tick();
        chk("rst_mid_no_done", 128'(seen_done), '0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            shift_in_en  = 1'($urandom % 2);
            shift_in_sel = 2'($urandom % 4);
            shift_in_bit = 1'($urandom % 2);
            wb_en        = ($urandom % 8) == 0;
            wb_sel       = 2'($urandom % 4);
            wb_val       = {$urandom, $urandom, $urandom, $urandom};
            rd_start     = ($urandom % 12) == 0;
            rd_sel       = 2'($urandom % 4);
            rst_n        = ($urandom % 900) != 0;
            tick();
        end
        idle_in();
        rst_n = 1'b1;
        repeat (140) tick();
        chk("queue_drained", 128'(exp_q.size()), '0);

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
